crc_table_gen: RTL and testbench
================================

Name: crc_table_gen

Overview:
- Run-time generator for the 256×32 CRC-32 lookup tables that the pipelined LUT CRC engine reads.
- It is the writer for those tables. Given a reflected polynomial and a byte offset k, it computes every entry T_k[i] by bit-serial LFSR stepping.
- Each entry is pushed to a table RAM through a valid/ready write port, so any slice table (ev0, ev1, …) can be rebuilt without re-synthesis.

Parameters:
- BITS_PER_CYCLE, 1, LFSR bit-steps applied per COMPUTE cycle. Legal values are 1, 2, 4, 8; other values are an elaboration error.
- OFFSET_W, 6, width of the offset input. Maximum k is 2^OFFSET_W − 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- poly  in  32  reflected polynomial (e.g. 32'hEDB88320); latched on accepted start
- offset  in  OFFSET_W  number of trailing zero bytes k; latched on accepted start
- busy  out  1  high from the cycle after an accepted start through the final write handshake
- done  out  1  one-cycle pulse the cycle after the last write handshake
- wr_en  out  1  write valid
- wr_addr  out  8  table index i
- wr_data  out  32  T_k[i]
- wr_ready  in  1  sink accepts the write when wr_en && wr_ready

Behaviour:
- Reset values: state=IDLE; busy, done, wr_en = 0; wr_addr, wr_data = 0; latched poly and offset = 0. Reset wins over any other event in the same cycle.
- Entry definition: c = {24'h0, i}. Apply S = 8·(k+1) steps of c = c[0] ? (c>>1)^poly : (c>>1). T_k[i] is the final c.
- Step count: one COMPUTE cycle applies BITS_PER_CYCLE steps. An entry therefore takes S/BITS_PER_CYCLE cycles, which is always an integer.
- IDLE: on start=1, latch poly and offset, set entry=0, c=0, step counter=0, and go to COMPUTE next cycle with busy=1. With start=0, stay in IDLE.
- COMPUTE: on the cycle that completes step S, register the result and go to WRITE. wr_en=1 in the following cycle, with wr_addr=entry and wr_data=c.
- First-write latency: if start is high at edge N, wr_en rises after edge N+S/BITS_PER_CYCLE.
- WRITE: hold wr_en, wr_addr and wr_data stable until wr_ready. On handshake:
  - entry==255: go to IDLE, busy=0, done=1 for one cycle.
  - otherwise: entry+1, c=entry+1, go to COMPUTE.
- wr_en is low during COMPUTE. Every address 0..255 is written exactly once, in ascending order.
- Throughput with wr_ready tied high: 256·(S/BITS_PER_CYCLE + 1) cycles per table. Example: 2304 cycles for k=0, BITS_PER_CYCLE=1.
- start while busy is ignored. Changes to poly or offset during a run have no effect.
- wr_ready low for any length stalls in WRITE without data corruption. wr_ready high outside WRITE is ignored.
- start in the same cycle as done is a fresh, accepted request.
- Reset mid-run: wr_en drops the next cycle, no further writes are issued, and done does not pulse.
- All arithmetic is 32-bit unsigned. The entry counter is 8-bit and the step counter is 11-bit.

Decomposition:
- Shared package crc_pkg:
  - CRC_W=32
  - TBL_ADDR_W=8
  - CRC32_POLY_REFL=32'hEDB88320
  - gen_state_t enum {IDLE, COMPUTE, WRITE}
- One sub-module, crc_lfsr_step. It is combinational and applies BITS_PER_CYCLE reflected shift/xor steps to a 32-bit value under a given poly.
- The top holds the FSM, counters and the output registers.

Test Plan:
- poly=EDB88320, offset=0, wr_ready=1, BITS_PER_CYCLE=1 -> 256 writes:
  - [0]=00000000, [1]=77073096, [0x80]=EDB88320, [0xFF]=2D02EF8D.
  - done is high 2304 cycles after start, and busy low the same cycle.
- offset=1, 2, 3 with poly=EDB88320 -> [1]=191B3141, 01C26A37, B8BC6765 respectively; [0]=0 in each case.
- wr_ready toggled pseudo-randomly -> wr_addr and wr_data are stable while stalled, there are no duplicate or missing addresses, and the table matches a golden model.
- start pulsed at entry 10 mid-run and poly changed -> ignored; the output table equals the original-poly table.
- rst asserted during entry 100 WRITE -> wr_en=0 the next cycle and done never pulses. A new start after reset produces a full correct table from [0].
- BITS_PER_CYCLE=8, offset=0 -> identical table to BITS_PER_CYCLE=1, with 512 total cycles when wr_ready=1.

Source files
------------

// File: rtl/crc_pkg.sv
// crc_pkg: shared constants, state encoding and parameter check for the CRC table generator
package crc_pkg;
  localparam int CRC_W = 32;
  localparam int TBL_ADDR_W = 8;
  localparam logic [CRC_W-1:0] CRC32_POLY_REFL = 32'hEDB88320;
  typedef enum logic [1:0] {IDLE, COMPUTE, WRITE} gen_state_t;
  function automatic bit bpc_legal(input int b);
    return b == 1 || b == 2 || b == 4 || b == 8;
  endfunction
endpackage

// File: rtl/crc_table_gen_if.sv
// crc_table_gen_if: request and table-RAM write port of the CRC table generator
interface crc_table_gen_if #(parameter int OFFSET_W = 6);
  import crc_pkg::*;
  logic start;
  logic [CRC_W-1:0] poly;
  logic [OFFSET_W-1:0] offset;
  logic busy;
  logic done;
  logic wr_en;
  logic wr_ready;
  logic [TBL_ADDR_W-1:0] wr_addr;
  logic [CRC_W-1:0] wr_data;
  modport master (output start, poly, offset, wr_ready, input busy, done, wr_en, wr_addr, wr_data);
  modport slave (input start, poly, offset, wr_ready, output busy, done, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/crc_lfsr_step.sv
// crc_lfsr_step: N reflected shift/xor LFSR steps of a 32-bit value, purely combinational
module crc_lfsr_step
  import crc_pkg::*;
#(parameter int N = 1)
(
  input  logic [CRC_W-1:0] i_c,
  input  logic [CRC_W-1:0] i_poly,
  output logic [CRC_W-1:0] o_c
);
  always_comb begin
    o_c = i_c;
    for (int j = 0; j < N; j++) o_c = o_c[0] ? (o_c >> 1) ^ i_poly : o_c >> 1;
  end
endmodule

// File: rtl/crc_table_gen.sv
// crc_table_gen: computes T_k[0..255] by bit-serial LFSR stepping and writes each entry out
module crc_table_gen
  import crc_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int OFFSET_W = 6
)
(
  input logic clk,
  input logic rst,
  crc_table_gen_if.slave bus
);
  gen_state_t r_state, w_next;
  logic [CRC_W-1:0] r_poly, r_c, w_c_step;
  logic [OFFSET_W-1:0] r_offset;
  logic [TBL_ADDR_W-1:0] r_entry;
  logic [10:0] r_step, w_steps, w_step_nxt;
  logic r_done, w_last_step, w_hs, w_last_entry;
  if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end
  crc_lfsr_step #(.N(BITS_PER_CYCLE)) u_step (.i_c(r_c), .i_poly(r_poly), .o_c(w_c_step));
  // S = 8*(k+1) steps per entry; the step counter restarts at zero for every entry
  assign w_steps = 11'((32'(r_offset) + 32'd1) << 3);
  assign w_step_nxt = r_step + 11'(BITS_PER_CYCLE);
  assign w_last_step = w_step_nxt == w_steps;
  assign w_hs = r_state == WRITE && bus.wr_ready;
  assign w_last_entry = r_entry == 8'hFF;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state == IDLE ? (bus.start ? COMPUTE : IDLE) :
             r_state == COMPUTE ? (w_last_step ? WRITE : COMPUTE) :
             w_hs ? (w_last_entry ? IDLE : COMPUTE) : WRITE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_poly <= '0;
      r_offset <= '0;
      r_entry <= '0;
      r_c <= '0;
      r_step <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_hs && w_last_entry;
      if (r_state == IDLE && bus.start) begin
        r_poly <= bus.poly;
        r_offset <= bus.offset;
        r_entry <= '0;
        r_c <= '0;
        r_step <= '0;
      end else if (r_state == COMPUTE) begin
        r_c <= w_c_step;
        r_step <= w_last_step ? 11'd0 : w_step_nxt;
      end else if (w_hs && !w_last_entry) begin
        r_entry <= r_entry + 8'd1;
        r_c <= 32'(r_entry) + 32'd1;
      end
    end
  end
  always_comb begin
    bus.wr_en = r_state == WRITE;
    bus.wr_addr = r_entry;
    bus.wr_data = r_c;
    bus.busy = r_state != IDLE;
    bus.done = r_done;
  end
endmodule

// File: tb/tb_crc_table_gen.sv
// tb_crc_table_gen: directed and randomized table runs checked against a byte-wise CRC model
module tb_crc_table_gen;
  import crc_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sel = 1'b0, wr_ready = 1'b0;
  logic [31:0] poly = '0;
  logic [5:0] offset = '0;
  int checks = 0, errors = 0;
  logic [31:0] got [256];
  logic [31:0] t0 [256];
  logic [31:0] ref_tbl [256];
  always #5 clk = ~clk;
  crc_table_gen_if #(.OFFSET_W(6)) b1 ();
  crc_table_gen_if #(.OFFSET_W(6)) b8 ();
  assign b1.start = start & ~sel;
  assign b8.start = start & sel;
  assign b1.poly = poly;
  assign b8.poly = poly;
  assign b1.offset = offset;
  assign b8.offset = offset;
  assign b1.wr_ready = wr_ready;
  assign b8.wr_ready = wr_ready;
  crc_table_gen #(.BITS_PER_CYCLE(1), .OFFSET_W(6)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  crc_table_gen #(.BITS_PER_CYCLE(8), .OFFSET_W(6)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  wire w_busy = sel ? b8.busy : b1.busy;
  wire w_done = sel ? b8.done : b1.done;
  wire w_en = sel ? b8.wr_en : b1.wr_en;
  wire [7:0] w_addr = sel ? b8.wr_addr : b1.wr_addr;
  wire [31:0] w_data = sel ? b8.wr_data : b1.wr_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // T_0 from the bit rule on a lone byte, then k zero bytes folded in byte-at-a-time
  task automatic build_ref(input logic [31:0] p, input int k);
    logic [31:0] c;
    for (int a = 0; a < 256; a++) begin
      c = 32'(a);
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ p : c >> 1;
      t0[a] = c;
    end
    for (int a = 0; a < 256; a++) begin
      c = t0[a];
      for (int z = 0; z < k; z++) c = (c >> 8) ^ t0[c[7:0]];
      ref_tbl[a] = c;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_table(input bit s, input logic [31:0] p, input int k, input bit stall,
                           input int inj, input int rst_at, input int exp_cyc, input int exp_first,
                           input bit chain);
    int cyc = 0, first = -1, nwr = 0, exp_addr = 0, nd = 0, nw = 0;
    bit prev_stall = 1'b0, aborted = 1'b0, injected = 1'b0;
    logic [7:0] pa = '0;
    logic [31:0] pd = '0;
    build_ref(p, k);
    sel = s;
    poly = p;
    offset = 6'(k);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(w_busy), 32'd1);
    while (!w_done && cyc < 20000) begin
      start = 1'b0;
      if (prev_stall) begin
        chk("stall_addr", 32'(w_addr), 32'(pa));
        chk("stall_data", w_data, pd);
      end
      if (w_en && first < 0) first = cyc;
      if (rst_at >= 0 && w_en && w_addr == 8'(rst_at)) begin
        rst = 1'b1;
        wr_ready = 1'b0;
        @(negedge clk);
        chk("wr_en_after_rst", 32'(w_en), 32'd0);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (inj >= 0 && w_en && w_addr == 8'(inj) && !injected) begin
        start = 1'b1;
        poly = ~p;
        offset = 6'(k + 1);
        injected = 1'b1;
      end
      wr_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_en && wr_ready) begin
        chk("addr_order", 32'(w_addr), 32'(exp_addr));
        chk("entry_data", w_data, ref_tbl[w_addr]);
        got[w_addr] = w_data;
        exp_addr++;
        nwr++;
      end
      prev_stall = w_en && !wr_ready;
      pa = w_addr;
      pd = w_data;
      @(negedge clk);
      cyc++;
    end
    if (aborted) begin
      repeat (40) begin
        @(negedge clk);
        nd += int'(w_done);
        nw += int'(w_en);
      end
      chk("no_done_after_rst", 32'(nd), 32'd0);
      chk("no_write_after_rst", 32'(nw), 32'd0);
    end else begin
      chk("done_seen", 32'(w_done), 32'd1);
      chk("busy_at_done", 32'(w_busy), 32'd0);
      chk("write_count", 32'(nwr), 32'd256);
      if (exp_cyc > 0) chk("cycles_to_done", 32'(cyc), 32'(exp_cyc));
      chk("first_write_latency", 32'(first), 32'(exp_first));
      start = chain;
      @(negedge clk);
      start = 1'b0;
      if (chain) chk("start_on_done_busy", 32'(w_busy), 32'd1);
      else chk("done_one_cycle", 32'(w_done), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] k1 [4];
    int rk;
    k1[0] = 32'h77073096;
    k1[1] = 32'h191B3141;
    k1[2] = 32'h01C26A37;
    k1[3] = 32'hB8BC6765;
    do_reset();
    @(negedge clk);
    chk("rst_busy", 32'(b1.busy), 32'd0);
    chk("rst_done", 32'(b1.done), 32'd0);
    chk("rst_wr_en", 32'(b1.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(b1.wr_addr), 32'd0);
    chk("rst_wr_data", b1.wr_data, 32'd0);
    chk("rst_wr_en_b8", 32'(b8.wr_en), 32'd0);
    run_table(1'b0, CRC32_POLY_REFL, 0, 1'b0, -1, -1, 2304, 8, 1'b0);
    chk("t0_00", got[0], 32'h00000000);
    chk("t0_01", got[1], 32'h77073096);
    chk("t0_80", got[8'h80], 32'hEDB88320);
    chk("t0_ff", got[8'hFF], 32'h2D02EF8D);
    for (int k = 1; k < 4; k++) begin
      run_table(1'b0, CRC32_POLY_REFL, k, 1'b0, -1, -1, 256 * (8 * (k + 1) + 1), 8 * (k + 1), 1'b0);
      chk("tk_01", got[1], k1[k]);
      chk("tk_00", got[0], 32'h0);
    end
    rk = int'($urandom_range(0, 2));
    run_table(1'b0, $urandom, rk, 1'b1, -1, -1, 0, 8 * (rk + 1), 1'b0);
    run_table(1'b0, CRC32_POLY_REFL, 0, 1'b1, 10, -1, 0, 8, 1'b0);
    chk("inject_t0_01", got[1], 32'h77073096);
    run_table(1'b0, CRC32_POLY_REFL, 1, 1'b0, -1, 100, 0, 16, 1'b0);
    run_table(1'b0, CRC32_POLY_REFL, 0, 1'b1, -1, -1, 0, 8, 1'b0);
    chk("after_rst_t0_ff", got[8'hFF], 32'h2D02EF8D);
    run_table(1'b1, CRC32_POLY_REFL, 0, 1'b0, -1, -1, 512, 1, 1'b1);
    chk("bpc8_t0_80", got[8'h80], 32'hEDB88320);
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
